sw_traceback_engine: RTL and testbench

- Walks the stored PE direction bits backwards, from a given end cell to the matrix origin (0,0).
- Reconstructs the affine-gap alignment path across the V, I and D layers.
- Emits one alignment operation per step on a valid/ready stream.
- Sits after the systolic PE array and the direction memory. It is the consumer (reader) of the direction words the PEs produce.

---
 rtl/sw_traceback_engine.sv | 165 ++++++++++++++++
 tb/tb_sw_traceback_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_traceback_engine.sv
// Affine-gap Smith-Waterman traceback: walks stored direction words from an end
// cell back to (0,0) and streams one alignment operation per step.
module sw_traceback_engine #(
    parameter int unsigned ROW_W = 10,
    parameter int unsigned COL_W = 10,
    parameter int unsigned LEN_W = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    output logic             o_busy,
    output logic             o_rd_en,
    output logic [ROW_W-1:0] o_rd_row,
    output logic [COL_W-1:0] o_rd_col,
    input  logic [3:0]       i_rd_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_op,
    output logic             o_last,
    output logic             o_done,
    output logic [LEN_W-1:0] o_len
);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_WAIT, S_EMIT, S_DONE} state_t;
    typedef enum logic [1:0] {L_V, L_I, L_D} layer_t;

    localparam logic [1:0]       OP_MATCH = 2'd0;
    localparam logic [1:0]       OP_INS   = 2'd1;
    localparam logic [1:0]       OP_DEL   = 2'd2;
    localparam logic [LEN_W-1:0] CNT_MAX  = '1;

    state_t           state, state_d;
    layer_t           layer, layer_d;
    logic [ROW_W-1:0] row, row_d;
    logic [COL_W-1:0] col, col_d;
    logic [LEN_W-1:0] cnt, cnt_d, cnt_inc;
    logic [1:0]       op_d;
    logic [LEN_W-1:0] len_d;
    logic             rd_en_d, valid_d, last_d, done_d, busy_d;
    logic [ROW_W-1:0] rd_row_d;
    logic [COL_W-1:0] rd_col_d;
    logic [1:0]       v_dir;
    logic             i_open, d_open;

    assign v_dir   = i_rd_data[3:2];
    assign i_open  = i_rd_data[1];
    assign d_open  = i_rd_data[0];
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + LEN_W'(1);

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            layer    <= L_V;
            row      <= '0;
            col      <= '0;
            cnt      <= '0;
            o_op     <= OP_MATCH;
            o_len    <= '0;
            o_rd_en  <= 1'b0;
            o_rd_row <= '0;
            o_rd_col <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_d;
            layer    <= layer_d;
            row      <= row_d;
            col      <= col_d;
            cnt      <= cnt_d;
            o_op     <= op_d;
            o_len    <= len_d;
            o_rd_en  <= rd_en_d;
            o_rd_row <= rd_row_d;
            o_rd_col <= rd_col_d;
            o_valid  <= valid_d;
            o_last   <= last_d;
            o_done   <= done_d;
            o_busy   <= busy_d;
        end
    end

    // Next state; outputs are looked ahead from the next state so they line up with it
    always_comb begin
        state_d = state;
        layer_d = layer;
        row_d   = row;
        col_d   = col;
        cnt_d   = cnt;
        op_d    = o_op;
        len_d   = o_len;

        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    row_d   = i_row;
                    col_d   = i_col;
                    layer_d = L_V;
                    cnt_d   = '0;
                    len_d   = '0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                // Edges force straight gaps regardless of the current layer
                if (row == '0 && col == '0) begin
                    len_d   = cnt;
                    state_d = S_DONE;
                end else if (row == '0) begin
                    op_d    = OP_INS;
                    col_d   = col - COL_W'(1);
                    state_d = S_EMIT;
                end else if (col == '0) begin
                    op_d    = OP_DEL;
                    row_d   = row - ROW_W'(1);
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (layer == L_D || (layer == L_V && v_dir == 2'd2)) begin
                    op_d    = OP_DEL;
                    row_d   = row - ROW_W'(1);
                    layer_d = d_open ? L_V : L_D;
                end else if (layer == L_I || (layer == L_V && v_dir == 2'd3)) begin
                    op_d    = OP_INS;
                    col_d   = col - COL_W'(1);
                    layer_d = i_open ? L_V : L_I;
                end else begin
                    op_d    = OP_MATCH;
                    row_d   = row - ROW_W'(1);
                    col_d   = col - COL_W'(1);
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (i_ready) begin
                    cnt_d = cnt_inc;
                    if (o_last) begin
                        len_d   = cnt_inc;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_en_d  = (state_d == S_STEP) && (row_d != '0) && (col_d != '0);
        rd_row_d = rd_en_d ? row_d : o_rd_row;
        rd_col_d = rd_en_d ? col_d : o_rd_col;
        valid_d  = (state_d == S_EMIT);
        last_d   = (state_d == S_EMIT) && (row_d == '0) && (col_d == '0);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_sw_traceback_engine.sv
// Self-checking bench for sw_traceback_engine: path model over a bench-side direction
// memory, per-cycle stream/read checker, directed cases plus randomized paths.
module tb_sw_traceback_engine;

    localparam int unsigned ROW_W = 10;
    localparam int unsigned COL_W = 10;
    localparam int unsigned LEN_W = 11;
    localparam int MD = 16;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [ROW_W-1:0] i_row;
    logic [COL_W-1:0] i_col;
    logic             o_busy;
    logic             o_rd_en;
    logic [ROW_W-1:0] o_rd_row;
    logic [COL_W-1:0] o_rd_col;
    logic [3:0]       i_rd_data;
    logic             o_valid;
    logic             i_ready;
    logic [1:0]       o_op;
    logic             o_last;
    logic             o_done;
    logic [LEN_W-1:0] o_len;

    sw_traceback_engine #(.ROW_W(ROW_W), .COL_W(COL_W), .LEN_W(LEN_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_row(i_row), .i_col(i_col),
        .o_busy(o_busy), .o_rd_en(o_rd_en), .o_rd_row(o_rd_row), .o_rd_col(o_rd_col),
        .i_rd_data(i_rd_data), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op),
        .o_last(o_last), .o_done(o_done), .o_len(o_len)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [3:0] mem [MD][MD];
    int exp_op[$];
    int exp_rd_r[$];
    int exp_rd_c[$];
    int exp_len, exp_cycles;
    int n_checks = 0, n_fail = 0;
    int rdy_mode;
    bit done_seen, stalled;
    int prev_op, prev_last, stall_cnt;
    int cyc_cnt = 0, t0, t_done;
    int m_r, m_c, m_o;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference path: walk the layers directly over the memory contents
    task automatic build_expect(input int r0, input int c0);
        int r, c, layer, sum;
        logic [3:0] w;
        r = r0; c = c0; layer = 0; sum = 0;
        exp_op.delete(); exp_rd_r.delete(); exp_rd_c.delete();
        while (!(r == 0 && c == 0)) begin
            if (r == 0) begin
                exp_op.push_back(1); c--; sum += 2;
            end else if (c == 0) begin
                exp_op.push_back(2); r--; sum += 2;
            end else begin
                w = mem[r][c];
                exp_rd_r.push_back(r); exp_rd_c.push_back(c);
                sum += 3;
                if (layer == 2 || (layer == 0 && w[3:2] == 2'd2)) begin
                    exp_op.push_back(2); r--; layer = w[0] ? 0 : 2;
                end else if (layer == 1 || (layer == 0 && w[3:2] == 2'd3)) begin
                    exp_op.push_back(1); c--; layer = w[1] ? 0 : 1;
                end else begin
                    exp_op.push_back(0); r--; c--;
                end
            end
        end
        exp_len = exp_op.size();
        exp_cycles = (exp_len == 0) ? 2 : sum + 1;
    endtask

    task automatic fill_const(input logic [3:0] w);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) mem[r][c] = w;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) mem[r][c] = 4'($urandom);
    endtask

    // Direction memory: one-cycle read latency, junk on idle cycles
    always @(posedge i_clk) begin
        if (o_rd_en && int'(o_rd_row) < MD && int'(o_rd_col) < MD)
            i_rd_data <= mem[o_rd_row][o_rd_col];
        else
            i_rd_data <= 4'($urandom);
    end

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    // Ready driver: 0 = always high, 1 = random, 2 = held low
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (rdy_mode == 1) i_ready = 1'($urandom_range(0, 1));
            else i_ready = (rdy_mode == 0);
        end
    end

    // Per-cycle checker of the read and operation streams against the model
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_rd_en || o_valid)
                check({o_busy, o_rd_en, o_valid} == (o_rd_en ? 3'b110 : 3'b101), "ctl_excl",
                      int'({o_busy, o_rd_en, o_valid}), o_rd_en ? 6 : 5);
            if (o_rd_en) begin
                if (exp_rd_r.size() == 0) check(1'b0, "rd_unexpected", 1, 0);
                else begin
                    m_r = exp_rd_r.pop_front();
                    m_c = exp_rd_c.pop_front();
                    check(int'(o_rd_row) == m_r && int'(o_rd_col) == m_c, "rd_addr",
                          int'(o_rd_row) * 1000 + int'(o_rd_col), m_r * 1000 + m_c);
                end
            end
            if (o_valid) begin
                if (stalled)
                    check(int'(o_op) == prev_op && int'(o_last) == prev_last, "stall_hold",
                          int'(o_op) * 10 + int'(o_last), prev_op * 10 + prev_last);
                if (!i_ready) stall_cnt++;
                else if (exp_op.size() == 0) check(1'b0, "op_unexpected", int'(o_op), -1);
                else begin
                    m_o = exp_op.pop_front();
                    check(int'(o_op) == m_o, "op", int'(o_op), m_o);
                    check(o_last == (exp_op.size() == 0), "last", int'(o_last),
                          int'(exp_op.size() == 0));
                end
            end
            stalled   = o_valid && !i_ready;
            prev_op   = int'(o_op);
            prev_last = int'(o_last);
            if (o_done) begin
                check(int'(o_len) == exp_len, "len", int'(o_len), exp_len);
                check(exp_op.size() + exp_rd_r.size() == 0, "ops_left",
                      exp_op.size() + exp_rd_r.size(), 0);
                done_seen = 1'b1;
                t_done = cyc_cnt;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic start_tb(input int r, input int c);
        build_expect(r, c);
        done_seen = 1'b0;
        @(posedge i_clk); #1;
        i_row = ROW_W'(r); i_col = COL_W'(c); i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t0 = cyc_cnt;
    endtask

    task automatic finish_tb(input bit timed, input int lit_len);
        for (int k = 0; k < 3000 && !done_seen; k++) @(posedge i_clk);
        check(done_seen, "done_timeout", int'(done_seen), 1);
        if (done_seen && timed)
            check(t_done - t0 + 1 == exp_cycles, "latency", t_done - t0 + 1, exp_cycles);
        if (lit_len >= 0) check(int'(o_len) == lit_len, "len_lit", int'(o_len), lit_len);
        @(negedge i_clk);
        check(!o_busy && !o_done && int'(o_len) == exp_len, "post_done",
              int'({o_busy, o_done}) * 10000 + int'(o_len), exp_len);
    endtask

    task automatic wait_rd();
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_rd_en) return;
        end
        check(1'b0, "rd_timeout", 0, 1);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_row = '0; i_col = '0; rdy_mode = 0;
        fill_const(4'b0000);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check({o_busy, o_rd_en, o_valid, o_last, o_done} == 5'b0 && o_op == 2'd0 && o_len == '0
              && o_rd_row == '0 && o_rd_col == '0, "reset_state",
              int'({o_busy, o_rd_en, o_valid, o_last, o_done, o_op}), 0);
        @(posedge i_clk); #1; i_rst = 1'b0;

        // Origin start: no reads, no ops
        start_tb(0, 0);
        finish_tb(1'b1, 0);

        // All-diagonal 2x2
        fill_const(4'b0100);
        start_tb(2, 2);
        check(exp_rd_r.size() == 2 && exp_rd_r[1] == 1 && exp_op[0] == 0 && exp_op[1] == 0,
              "model_pin_22", exp_rd_r.size(), 2);
        finish_tb(1'b1, 2);

        // Deletion gap opened and closed, then diagonal
        fill_const(4'b0000);
        mem[3][1] = 4'b1000; mem[2][1] = 4'b0001; mem[1][1] = 4'b0100;
        start_tb(3, 1);
        check(exp_len == 3 && exp_op[0] == 2 && exp_op[1] == 2 && exp_op[2] == 0
              && exp_rd_r[1] == 2 && exp_rd_c[2] == 1, "model_pin_31", exp_len, 3);
        finish_tb(1'b1, 3);

        // Top edge: insertions only
        start_tb(0, 3);
        check(exp_cycles == 7 && exp_rd_r.size() == 0, "model_pin_03", exp_cycles, 7);
        finish_tb(1'b1, 3);

        // Left edge inside an open insertion gap still yields deletions
        fill_const(4'b1100);
        start_tb(2, 1);
        finish_tb(1'b1, 3);

        // Backpressure during the first emit
        fill_const(4'b0100);
        stall_cnt = 0;
        start_tb(2, 2);
        wait_rd();
        rdy_mode = 2;
        repeat (7) @(posedge i_clk);
        rdy_mode = 0;
        finish_tb(1'b0, 2);
        check(stall_cnt == 5, "stall_cycles", stall_cnt, 5);

        // Reset during WAIT, with a simultaneous start that must lose
        start_tb(3, 3);
        wait_rd();
        @(posedge i_clk); #1;
        i_rst = 1'b1; i_start = 1'b1; i_row = 10'd1; i_col = 10'd1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        check({o_busy, o_rd_en, o_valid, o_last, o_done} == 5'b0 && o_op == 2'd0 && o_len == '0
              && o_rd_row == '0 && o_rd_col == '0, "rst_mid",
              int'({o_busy, o_rd_en, o_valid, o_last, o_done, o_op}), 0);
        @(negedge i_clk);
        check(!o_busy, "rst_beats_start", int'(o_busy), 0);
        start_tb(1, 1);
        finish_tb(1'b1, 1);

        // Randomized paths and ready patterns
        for (int n = 0; n < 40; n++) begin
            int r, c;
            fill_rand();
            r = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 11));
            c = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 11));
            rdy_mode = int'($urandom_range(0, 1));
            @(posedge i_clk);
            start_tb(r, c);
            finish_tb(rdy_mode == 0, -1);
            rdy_mode = 0;
        end

        repeat (3) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
